// File: rtl/gen_ctrl.sv
// gen_ctrl -- sequencer for a cellular-automaton grid and its seeding LFSR.
//
// States: IDLE (grid cleared, LFSR held in reset), SEED (LFSR free-runs for
// SEED_LEN cycles while the grid loads from it), RUN (grid advances once every
// div+1 cycles), PAUSE (frozen), STEP (one generation from PAUSE).
//
// Build option: define GEN_CTRL_STEP_EN to implement single-step support.
// Without it the step input is accepted but has no effect, and code 4 (STEP)
// is treated like the other unused codes (IDLE outputs, return to IDLE).

module gen_ctrl #(
  parameter int DIV_W    = 8,
  parameter int GEN_W    = 16,
  parameter int SEED_LEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             lfsr_load,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             lfsr_rst,
  output logic             rst,
  output logic             en,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STEP  = 3'd4
  } state_e;

  // The seed counter is 16 bits wide, matching the legal SEED_LEN range.
  localparam logic [15:0]      SEED_LAST = 16'(SEED_LEN - 1);
  localparam logic [GEN_W-1:0] GEN_MAX   = {GEN_W{1'b1}};

  state_e           state_q, state_d;
  logic [15:0]      seed_cnt_q, seed_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             tick;
  logic             enter_run;
  logic             enter_clear;

  // Rate divider comparison; comparing against the live div value means a
  // lowered divider takes effect on the very next RUN update.
  assign tick = (div_cnt_q >= div);

  // Next-state selection with fixed priority stop > lfsr_load > start > step.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // stop has nothing to do in IDLE, so lower-priority requests proceed.
        if (lfsr_load)  state_d = ST_SEED;
        else if (start) state_d = ST_RUN;
      end
      ST_SEED: begin
        // A repeated lfsr_load would only restart seeding; it is ignored.
        if (stop)                          state_d = ST_IDLE;
        else if (start)                    state_d = ST_RUN;
        else if (seed_cnt_q == SEED_LAST)  state_d = ST_PAUSE;
      end
      ST_RUN: begin
        if (stop)           state_d = ST_PAUSE;
        else if (lfsr_load) state_d = ST_SEED;
        else                state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (stop)           state_d = ST_IDLE;
        else if (lfsr_load) state_d = ST_SEED;
        else if (start)     state_d = ST_RUN;
`ifdef GEN_CTRL_STEP_EN
        else if (step)      state_d = ST_STEP;
`else
        else if (step)      state_d = ST_PAUSE;
`endif
      end
`ifdef GEN_CTRL_STEP_EN
      ST_STEP: state_d = ST_PAUSE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_run   = (state_d == ST_RUN) && (state_q != ST_RUN);
  assign enter_clear = ((state_d == ST_SEED) || (state_d == ST_IDLE)) &&
                       (state_q != state_d);

  // Seed length counter: zeroed on SEED entry, counts SEED cycles.
  always_comb begin
    seed_cnt_d = seed_cnt_q;
    if ((state_d == ST_SEED) && (state_q != ST_SEED)) begin
      seed_cnt_d = '0;
    end else if (state_q == ST_SEED) begin
      seed_cnt_d = seed_cnt_q + 16'd1;
    end
  end

  // Run-rate divider: zeroed on RUN entry and on each tick; frozen elsewhere.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enter_run) begin
      div_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) div_cnt_d = '0;
      else      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Generation counter: counts enabled RUN/STEP cycles, saturating at max.
  always_comb begin
    gen_d = gen_q;
    if (enter_clear) begin
      gen_d = '0;
    end else if (en && ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                 (gen_q != GEN_MAX)) begin
      gen_d = gen_q + GEN_W'(1);
    end
  end

  // Moore outputs from the registered state (and divider count in RUN).
  always_comb begin
    lfsr_rst = 1'b1;
    rst      = 1'b1;
    en       = 1'b0;
    case (state_q)
      ST_SEED: begin
        lfsr_rst = 1'b0;
        rst      = 1'b1;
        en       = 1'b1;
      end
      ST_RUN: begin
        lfsr_rst = 1'b0;
        rst      = 1'b0;
        en       = tick;
      end
      ST_PAUSE: begin
        lfsr_rst = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
      end
`ifdef GEN_CTRL_STEP_EN
      ST_STEP: begin
        lfsr_rst = 1'b0;
        rst      = 1'b0;
        en       = 1'b1;
      end
`endif
      default: begin
        lfsr_rst = 1'b1;
        rst      = 1'b1;
        en       = 1'b0;
      end
    endcase
  end

  assign state_o   = state_q;
  assign gen_count = gen_q;

  // State and counter registers with asynchronous reset to IDLE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      seed_cnt_q <= '0;
      div_cnt_q  <= '0;
      gen_q      <= '0;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      div_cnt_q  <= div_cnt_d;
      gen_q      <= gen_d;
    end
  end

endmodule

// File: tb/tb_gen_ctrl.sv
// Directed bench for gen_ctrl with a scoreboard of expected values.
// A second instance with GEN_W=4 exercises generation-counter saturation.
`timescale 1ns/1ps

module tb_gen_ctrl;

  localparam int SEED_LEN_TB = 64;

  localparam logic [5:0] O_IDLE  = 6'b000_110;  // {state_o, lfsr_rst, rst, en}
  localparam logic [5:0] O_SEED  = 6'b001_011;
  localparam logic [5:0] O_RUN1  = 6'b010_001;
  localparam logic [5:0] O_PAUSE = 6'b011_000;
  localparam logic [5:0] O_STEP  = 6'b100_001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, lfsr_load = 1'b0, step = 1'b0;
  logic [7:0]  div = 8'd0;
  logic        lfsr_rst, rst, en;
  logic [15:0] gen_count;
  logic [2:0]  state_o;

  logic        start2 = 1'b0;
  logic        lfsr_rst2, rst2, en2;
  logic [3:0]  gen2;
  logic [2:0]  state2;

  logic [5:0]  outs, outs2;
  assign outs  = {state_o, lfsr_rst, rst, en};
  assign outs2 = {state2, lfsr_rst2, rst2, en2};

  always #5 clk = ~clk;

  gen_ctrl #(.DIV_W(8), .GEN_W(16), .SEED_LEN(SEED_LEN_TB)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .lfsr_load(lfsr_load), .step(step), .div(div),
    .lfsr_rst(lfsr_rst), .rst(rst), .en(en),
    .gen_count(gen_count), .state_o(state_o)
  );

  gen_ctrl #(.DIV_W(8), .GEN_W(4), .SEED_LEN(8)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .stop(1'b0),
    .lfsr_load(1'b0), .step(1'b0), .div(8'd0),
    .lfsr_rst(lfsr_rst2), .rst(rst2), .en(en2),
    .gen_count(gen2), .state_o(state2)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_gen = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %0h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, both instances.
    #2;
    push("rst_outs", 32'(O_IDLE));  check(32'(outs));
    push("rst_gen", 32'd0);         check(32'(gen_count));
    push("rst_outs2", 32'(O_IDLE)); check(32'(outs2));
    @(posedge clk);
    #2 reset = 1'b0;
    cyc();
    push("idle_outs", 32'(O_IDLE)); check(32'(outs));

    // Seeding: one-cycle lfsr_load, SEED for exactly SEED_LEN cycles.
    lfsr_load = 1'b1;
    cyc();
    lfsr_load = 1'b0;
    for (int i = 0; i < SEED_LEN_TB; i++) begin
      push($sformatf("seed_outs_%0d", i), 32'(O_SEED));
      check(32'(outs));
      cyc();
    end
    push("seed_done", 32'(O_PAUSE)); check(32'(outs));
    push("seed_gen", 32'd0);         check(32'(gen_count));

    // RUN from PAUSE with div=3: en on every 4th RUN cycle.
    div = 8'd3;
    start = 1'b1;
    push("run_entry", 32'(3'd2));
    cyc();
    check(32'(state_o));
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      push($sformatf("run_en_%0d", i), (i % 4 == 0) ? 32'd1 : 32'd0);
      check(32'(en));
      cyc();
    end
    push("run_gen40", 32'd10); check(32'(gen_count));

    // Lowering div below the running count forces an immediate update.
    cyc();
    cyc();
    push("div_hi_en", 32'd0); check(32'(en));
    div = 8'd1;
    #1;
    push("div_lo_en", 32'd1); check(32'(en));
    push("div_lo_gen", 32'd11);
    cyc();
    check(32'(gen_count));

    // stop beats lfsr_load in RUN, then the pair in PAUSE goes to IDLE.
    stop = 1'b1;
    lfsr_load = 1'b1;
    push("run_stop_pri", 32'(O_PAUSE));
    cyc();
    check(32'(outs));
    push("pause_gen", 32'd11); check(32'(gen_count));
    push("pause_stop_pri", 32'(O_IDLE));
    cyc();
    check(32'(outs));
    push("idle_gen_clr", 32'd0); check(32'(gen_count));
    stop = 1'b0;
    lfsr_load = 1'b0;

    // SEED left early by start, RUN at div=0, then stop into PAUSE.
    lfsr_load = 1'b1;
    cyc();
    lfsr_load = 1'b0;
    cyc();
    cyc();
    div = 8'd0;
    start = 1'b1;
    push("seed_early_run", 32'(O_RUN1));
    cyc();
    check(32'(outs));
    start = 1'b0;
    cyc();
    cyc();
    push("run_div0_gen", 32'd2); check(32'(gen_count));
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    push("stop_to_pause", 32'(O_PAUSE)); check(32'(outs));
    exp_gen = 3;
    push("pause_gen3", 32'(exp_gen)); check(32'(gen_count));

    // Single steps from PAUSE.
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
`ifdef GEN_CTRL_STEP_EN
      push($sformatf("step_outs_%0d", k), 32'(O_STEP));
      exp_gen++;
`else
      push($sformatf("step_outs_%0d", k), 32'(O_PAUSE));
`endif
      check(32'(outs));
      cyc();
      push($sformatf("step_back_%0d", k), 32'(O_PAUSE)); check(32'(outs));
    end
    push("step_gen", 32'(exp_gen)); check(32'(gen_count));

    // Asynchronous reset between edges while RUN is updating.
    start = 1'b1;
    cyc();
    start = 1'b0;
    push("pre_rst_run", 32'(O_RUN1)); check(32'(outs));
    cyc();
    #3 reset = 1'b1;
    #1;
    push("midrun_rst_outs", 32'(O_IDLE)); check(32'(outs));
    push("midrun_rst_gen", 32'd0);        check(32'(gen_count));
    #2 reset = 1'b0;
    cyc();
    push("post_rst_idle", 32'(O_IDLE)); check(32'(outs));

    // Saturation with GEN_W=4 over 20 RUN cycles at div=0.
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push($sformatf("sat_gen_%0d", i), (i > 15) ? 32'd15 : 32'(i));
      check(32'(gen2));
      cyc();
    end
    push("sat_final", 32'd15); check(32'(gen2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_ctrl.md
GEN_CTRL -- requirements
Module: gen_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, meaning the width of the run-rate divider.
REQ-002 The block SHALL have parameter GEN_W, default 16, meaning the width of the generation counter.
REQ-003 The block SHALL have parameter SEED_LEN, default 64, meaning the number of cycles the LFSR free-runs during seeding (legal range 1..2^16-1).
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port start  input  1  level request to enter RUN.
REQ-007 The block SHALL have port stop  input  1  level request: RUN to PAUSE; SEED or PAUSE to IDLE.
REQ-008 The block SHALL have port lfsr_load  input  1  level request to enter SEED.
REQ-009 The block SHALL have port step  input  1  level request for a single generation from PAUSE.
REQ-010 The block SHALL have port div  input  DIV_W  run-rate divider; one update every div+1 RUN cycles.
REQ-011 The block SHALL have port lfsr_rst  output  1  LFSR synchronous reset.
REQ-012 The block SHALL have port rst  output  1  grid-register clear/load-select.
REQ-013 The block SHALL have port en  output  1  grid/LFSR update enable.
REQ-014 The block SHALL have port gen_count  output  GEN_W  generations completed since last seed or IDLE.
REQ-015 The block SHALL have port state_o  output  3  current state code: IDLE=0, SEED=1, RUN=2, PAUSE=3, STEP=4.

Function
REQ-016 Inputs SHALL be sampled on the rising clk edge; a state change SHALL take effect one cycle after the request.
REQ-017 Requests SHALL have fixed priority stop > lfsr_load > start > step in every state.
REQ-018 IDLE SHALL drive lfsr_rst=1, rst=1, en=0; on lfsr_load go to SEED; on start go to RUN; otherwise stay; stop is ignored.
REQ-019 SEED SHALL drive lfsr_rst=0, rst=1, en=1, and SHALL load seed_cnt=0 on entry.
REQ-020 SEED SHALL increment seed_cnt each cycle and go to PAUSE after exactly SEED_LEN cycles in SEED.
REQ-021 In SEED, stop SHALL go to IDLE, start SHALL go to RUN early, and lfsr_load SHALL be ignored.
REQ-022 RUN SHALL drive lfsr_rst=0, rst=0, en=tick, where tick=1 when div_cnt>=div; div_cnt SHALL clear to 0 on tick and on RUN entry, else increment.
REQ-023 With div=0, tick SHALL be 1 on every RUN cycle; with div=N, the first tick SHALL occur on the (N+1)th RUN cycle.
REQ-024 Lowering div below div_cnt in RUN SHALL cause a tick on the next RUN cycle.
REQ-025 In RUN, stop SHALL go to PAUSE, lfsr_load SHALL go to SEED, and start SHALL hold RUN.
REQ-026 PAUSE SHALL drive lfsr_rst=0, rst=0, en=0; div_cnt SHALL hold its value.
REQ-027 In PAUSE, stop SHALL go to IDLE, lfsr_load SHALL go to SEED, start SHALL go to RUN, and step SHALL go to STEP.
REQ-028 STEP SHALL last exactly one cycle with lfsr_rst=0, rst=0, en=1, then go to PAUSE unconditionally.
REQ-029 gen_count SHALL increment by 1 on every cycle where en=1 in RUN or STEP, and SHALL saturate at 2^GEN_W-1 with no wrap.
REQ-030 gen_count SHALL clear to 0 on entry to SEED or IDLE.
REQ-031 Unused state codes 5..7 SHALL behave as IDLE outputs and SHALL go to IDLE on the next cycle.
REQ-032 Outputs lfsr_rst, rst, en and state_o SHALL be glitch-free Moore functions of registered state and div_cnt.

Reset
REQ-033 reset SHALL force state=IDLE, seed_cnt=0, div_cnt=0 and gen_count=0 asynchronously.
REQ-034 During reset, the outputs SHALL be lfsr_rst=1, rst=1, en=0, state_o=0.
REQ-035 reset asserted mid-SEED or mid-RUN SHALL abort immediately without completing a pending tick.

Configuration
REQ-036 With macro GEN_CTRL_STEP_EN defined, the step input and the STEP state SHALL be implemented as specified.
REQ-037 With GEN_CTRL_STEP_EN undefined, step SHALL be ignored, STEP SHALL be unreachable (code 4 treated as unused per REQ-031), and the port SHALL remain present.

Verification
REQ-038 The bench SHALL cover: reset, then lfsr_load=1 for 1 cycle with SEED_LEN=64 -> state_o=1 for exactly 64 cycles with en=1, rst=1, lfsr_rst=0, then state_o=3.
REQ-039 The bench SHALL cover: from PAUSE, start with div=3 held for 40 cycles -> en pulses every 4th cycle, gen_count=10.
REQ-040 The bench SHALL cover: in RUN with div=0, gen_count preset near max with GEN_W=4 over 20 cycles -> gen_count saturates at 15.
REQ-041 The bench SHALL cover: stop and lfsr_load asserted together in RUN -> PAUSE (stop wins); then the same pair in PAUSE -> IDLE with gen_count=0.
REQ-042 The bench SHALL cover, with GEN_CTRL_STEP_EN defined: step pulsed 3 times from PAUSE -> 3 single-cycle en pulses, gen_count+3; with the macro undefined -> no en and gen_count unchanged.
REQ-043 The bench SHALL cover: reset asserted mid-RUN between edges -> outputs 1/1/0 immediately and state_o=0.
